fill_arbiter: RTL and testbench
===============================

# fill_arbiter

Shares the DRAM-cache write path between two line-install requesters: write fills from the tag comparator (write hit/miss, line becomes dirty) and refills from the backing-memory read path (read-miss data, line installed clean). Grants one requester at a time, builds the tagged cache line `{VALID, DIRTY, TAG, BLANK, DATA}`, and issues it as a single-beat AXI write (AW+W) to the DRAM memory controller. Tracks outstanding B responses and throttles new grants against a fixed limit.

## Interface
- ADDR_WIDTH, `AXI_ADDR_WIDTH, request/AXI address width
- DATA_WIDTH, `AXI_DATA_WIDTH, line data width
- ID_WIDTH, `AXI_ID_WIDTH, AXI ID width
- TAG_SIZE, `TAG_SIZE, tag field width; equals 2 + TAG_WIDTH + BLANK_WIDTH
- TAG_WIDTH, `TAG_WIDTH, stored tag width
- BLANK_WIDTH, `BLANK_WIDTH, zero padding below the tag
- INDEX_WIDTH, `INDEX_WIDTH, set index width
- OFFSET_WIDTH, `OFFSET_WIDTH, byte offset width
- MAX_OUTSTANDING, 4, maximum AW handshakes without a B response (1..15)
- FILL_AXI_ID, 0, constant value driven on awid_o
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fill_valid_i  in  1  write-fill request
- fill_ready_o  out  1  write-fill accepted when high with fill_valid_i
- fill_data_i  in  ADDR_WIDTH+DATA_WIDTH  {addr, data}
- refill_valid_i  in  1  refill request
- refill_ready_o  out  1  refill accepted when high with refill_valid_i
- refill_data_i  in  ADDR_WIDTH+DATA_WIDTH  {addr, data}
- awid_o  out  ID_WIDTH  FILL_AXI_ID
- awaddr_o  out  ADDR_WIDTH  cache-line address
- awvalid_o  out  1  AW valid
- awready_i  in  1  AW ready
- wdata_o  out  TAG_SIZE+DATA_WIDTH  tagged line
- wlast_o  out  1  constant 1 while wvalid_o is high, else 0
- wvalid_o  out  1  W valid
- wready_i  in  1  W ready
- bid_i  in  ID_WIDTH  ignored
- bresp_i  in  2  write response
- bvalid_i  in  1  B valid
- bready_o  out  1  always 1 out of reset
- outstanding_o  out  4  current outstanding-write count
- err_o  out  1  sticky: a B response with bresp_i != 0 was received

## Operation
- FSM states:
  - S_IDLE:
    - A grant is possible only when outstanding < MAX_OUTSTANDING.
    - The granted requester's ready is driven combinationally high.
    - On valid&ready, the payload is registered and the FSM moves to S_SEND.
  - S_SEND:
    - awvalid_o and wvalid_o are driven high together.
    - Each channel keeps a done flag, set on its own handshake; a channel's valid drops after its handshake.
    - When both channels have completed, the FSM returns to S_IDLE. Completion is checked with each flag ORed with that cycle's handshake, so both channels may complete in the same cycle.
- Arbitration (default): round-robin.
  - A last-grant pointer flips on every grant.
  - When both requesters are valid, grant goes to the one not granted last.
  - The pointer resets to "fill", so refill wins the first tie.
  - With a single valid requester, that requester is granted.
- Line build:
  - awaddr_o = addr with bits [ADDR_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH] cleared.
  - wdata_o[TAG_SIZE+DATA_WIDTH-1] = 1 (VALID).
  - Next bit down = DIRTY: 1 for fill, 0 for refill.
  - [TAG_WIDTH+BLANK_WIDTH+DATA_WIDTH-1 : BLANK_WIDTH+DATA_WIDTH] = addr[ADDR_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH].
  - Blank bits are 0.
  - [DATA_WIDTH-1:0] = data.
- Outstanding counter:
  - +1 on AW handshake, −1 on B handshake, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
  - A B handshake at count 0 is ignored and sets err_o.
- err_o: set on a B handshake with bresp_i != 0; cleared only by reset.
- Ordering between the two requesters to the same index is not enforced here; upstream guarantees it.

## Timing
- Reset values: all valids, readys and err_o are 0, outstanding_o is 0, bready_o is 0, the FSM is in S_IDLE, and payload registers are 0. bready_o is 1 from the first clock after reset deasserts.
- Reset asserted mid-S_SEND: the transaction is dropped and all outputs return to their reset values immediately (asynchronous).
- Latency: a request accepted at edge N drives awvalid_o/wvalid_o from edge N+1.
- Throughput: with zero-wait AXI ready, at most one line every 2 cycles.
- No ready is asserted while in S_SEND or when outstanding == MAX_OUTSTANDING.
- AW and W payloads are held stable until their own handshake.
- A B response arriving in the same cycle as a grant decision is not counted toward that decision; the grant uses the registered count.

## Configuration
- FILL_ARB_REFILL_PRIO_EN:
  - Defined: fixed priority, refill always wins over fill, and the round-robin pointer is removed.
  - Undefined: round-robin as described above.

## Test plan
- Single fill, addr=0x0001_2340, data=0xA5, ready tied 1 → one AW with awaddr = addr with tag bits cleared, wdata VALID=1, DIRTY=1, tag field = addr tag bits, B okay → outstanding returns to 0.
- Both requesters valid for 4 requests each (default build) → grant order refill, fill, refill, fill…; with FILL_ARB_REFILL_PRIO_EN → all 4 refills first.
- awready_i delayed 3 cycles, wready_i immediate → W completes first, AW is held stable, FSM leaves S_SEND only after AW; with both readys in the same cycle → S_SEND lasts exactly 1 cycle.
- bvalid_i held 0 and MAX_OUTSTANDING=4 → after 4 writes no ready is asserted; a single B → exactly one more grant.
- B with bresp_i=2'b10 → err_o=1 and it stays high; a B at outstanding 0 → err_o=1, count stays 0.
- rst_n pulsed low mid-S_SEND → awvalid_o/wvalid_o drop asynchronously, and outstanding_o=0 after release.

Source files
------------

// File: rtl/fill_arbiter.sv
// fill_arbiter: grants write fills or refills one at a time and issues the tagged line as a single-beat AXI write.
// Build option FILL_ARB_REFILL_PRIO_EN: refill always beats fill (no round-robin pointer).
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 20
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 16
`endif
`ifndef BLANK_WIDTH
`define BLANK_WIDTH 2
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 10
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif

module fill_arbiter #(
    parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH        = `AXI_ID_WIDTH,
    parameter int TAG_SIZE        = `TAG_SIZE,
    parameter int TAG_WIDTH       = `TAG_WIDTH,
    parameter int BLANK_WIDTH     = `BLANK_WIDTH,
    parameter int INDEX_WIDTH     = `INDEX_WIDTH,
    parameter int OFFSET_WIDTH    = `OFFSET_WIDTH,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [ID_WIDTH-1:0] FILL_AXI_ID = {ID_WIDTH{1'b0}}
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fill_valid_i,
    output logic                           fill_ready_o,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
    input  logic                           refill_valid_i,
    output logic                           refill_ready_o,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
    output logic [ID_WIDTH-1:0]            awid_o,
    output logic [ADDR_WIDTH-1:0]          awaddr_o,
    output logic                           awvalid_o,
    input  logic                           awready_i,
    output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
    output logic                           wlast_o,
    output logic                           wvalid_o,
    input  logic                           wready_i,
    input  logic [ID_WIDTH-1:0]            bid_i,
    input  logic [1:0]                     bresp_i,
    input  logic                           bvalid_i,
    output logic                           bready_o,
    output logic [3:0]                     outstanding_o,
    output logic                           err_o
);

    localparam int REQ_W    = ADDR_WIDTH + DATA_WIDTH;
    localparam int LINE_LSB = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int LINE_W   = TAG_SIZE + DATA_WIDTH;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_WIDTH-1:0] awaddr_r;
    logic [LINE_W-1:0]   wdata_r;
    logic                aw_done_r;
    logic                w_done_r;
    logic                bready_r;
    logic                err_r;
    logic [3:0]          cnt_r;
    logic                can_grant_s;
    logic                pick_refill_s;
    logic                grant_s;
    logic [REQ_W-1:0]    req_s;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                b_hs_s;
    logic                b_dec_s;
    logic                unused_s;
`ifndef FILL_ARB_REFILL_PRIO_EN
    logic                last_refill_r;
`endif

    // Index+offset survive; the tag travels inside the line instead of the address.
    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] addr);
        line_addr = {ADDR_WIDTH{1'b0}};
        line_addr[LINE_LSB-1:0] = addr[LINE_LSB-1:0];
    endfunction

    function automatic logic [LINE_W-1:0] build_line(input logic [REQ_W-1:0] req, input logic dirty);
        build_line = {1'b1, dirty, req[REQ_W-1 -: TAG_WIDTH], {BLANK_WIDTH{1'b0}}, req[DATA_WIDTH-1:0]};
    endfunction

    assign awid_o        = FILL_AXI_ID;
    assign awaddr_o      = awaddr_r;
    assign wdata_o       = wdata_r;
    assign awvalid_o     = (state_r == S_SEND) && !aw_done_r;
    assign wvalid_o      = (state_r == S_SEND) && !w_done_r;
    assign wlast_o       = wvalid_o;
    assign bready_o      = bready_r;
    assign outstanding_o = cnt_r;
    assign err_o         = err_r;
    assign aw_hs_s       = awvalid_o && awready_i;
    assign w_hs_s        = wvalid_o && wready_i;
    assign b_hs_s        = bvalid_i && bready_r;
    assign b_dec_s       = b_hs_s && (cnt_r != 4'd0);
    assign unused_s      = ^bid_i;

    // Arbitration: grant only from idle with room for another outstanding write.
    always_comb begin
        can_grant_s = (state_r == S_IDLE) && (cnt_r < MAX_CNT);
`ifdef FILL_ARB_REFILL_PRIO_EN
        pick_refill_s = refill_valid_i;
`else
        pick_refill_s = refill_valid_i && (!fill_valid_i || !last_refill_r);
`endif
        refill_ready_o = can_grant_s && pick_refill_s;
        fill_ready_o   = can_grant_s && fill_valid_i && !pick_refill_s;
        grant_s        = fill_ready_o || refill_ready_o;
        if (refill_ready_o) begin
            req_s = refill_data_i;
        end else begin
            req_s = fill_data_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a grant starts a send; both channels done (flag or this cycle's handshake) ends it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_s) state_next_s = S_SEND;
                else         state_next_s = S_IDLE;
            end
            S_SEND: begin
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) state_next_s = S_IDLE;
                else                                                 state_next_s = S_SEND;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Payload capture on grant and per-channel completion flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= {LINE_W{1'b0}};
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (grant_s) begin
            awaddr_r  <= line_addr(req_s[REQ_W-1 -: ADDR_WIDTH]);
            wdata_r   <= build_line(req_s, fill_ready_o);
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            if (aw_hs_s) aw_done_r <= 1'b1;
            if (w_hs_s)  w_done_r  <= 1'b1;
        end
    end

`ifndef FILL_ARB_REFILL_PRIO_EN
    // Remember the last winner so a tie goes to the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_refill_r <= 1'b0;
        end else if (grant_s) begin
            last_refill_r <= refill_ready_o;
        end
    end
`endif

    // Outstanding-write count, sticky error and B ready; a B with nothing outstanding is an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 4'd0;
            err_r    <= 1'b0;
            bready_r <= 1'b0;
        end else begin
            bready_r <= 1'b1;
            if (b_hs_s && ((bresp_i != 2'b00) || (cnt_r == 4'd0))) err_r <= 1'b1;
            if (aw_hs_s && !b_dec_s) begin
                cnt_r <= cnt_r + 4'd1;
            end else if (b_dec_s && !aw_hs_s) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_fill_arbiter.sv
// Self-checking bench for fill_arbiter (default build): line-build table, directed corner sequences,
// and random traffic checked every cycle against a transaction-level reference model.
module tb_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fill_valid, refill_valid, awready, wready, bvalid;
    logic [95:0] fill_data, refill_data;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        fill_ready_o, refill_ready_o, awvalid_o, wlast_o, wvalid_o, bready_o, err_o;
    logic [3:0]  awid_o, outstanding_o;
    logic [31:0] awaddr_o;
    logic [83:0] wdata_o;

    int checks = 0;
    int failures = 0;
    bit grant_log[$];

    fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .fill_valid_i(fill_valid), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data),
        .refill_valid_i(refill_valid), .refill_ready_o(refill_ready_o), .refill_data_i(refill_data),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready),
        .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fill_valid = 1'b0; refill_valid = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        grant_log.delete();
    endtask

    // Reference model: one line in flight at a time, a write counter, sticky error, last winner.
    bit          m_busy, m_awd, m_wd, m_err, m_last_ref, m_bready;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [83:0] m_line;
    bit          p_room, p_fr, p_rr, p_awv, p_wv, p_aw_hs, p_w_hs, p_b_hs;
    logic [95:0] p_req;

    always_comb begin
        p_room  = !m_busy && (m_cnt < 4);
        p_rr    = p_room && refill_valid && (!fill_valid || !m_last_ref);
        p_fr    = p_room && fill_valid && !p_rr;
        p_req   = p_rr ? refill_data : fill_data;
        p_awv   = m_busy && !m_awd;
        p_wv    = m_busy && !m_wd;
        p_aw_hs = p_awv && awready;
        p_w_hs  = p_wv && wready;
        p_b_hs  = bvalid && m_bready;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_awd <= 1'b0; m_wd <= 1'b0; m_err <= 1'b0;
            m_last_ref <= 1'b0; m_bready <= 1'b0; m_cnt <= 0;
            m_addr <= 32'h0; m_line <= 84'h0;
        end else begin
            m_bready <= 1'b1;
            m_cnt <= m_cnt + (p_aw_hs ? 1 : 0) - ((p_b_hs && m_cnt > 0) ? 1 : 0);
            if (p_b_hs && (bresp != 2'b00 || m_cnt == 0)) m_err <= 1'b1;
            if (m_busy) begin
                if (p_aw_hs) m_awd <= 1'b1;
                if (p_w_hs) m_wd <= 1'b1;
                if ((m_awd || p_aw_hs) && (m_wd || p_w_hs)) m_busy <= 1'b0;
            end else if (p_fr || p_rr) begin
                m_busy <= 1'b1; m_awd <= 1'b0; m_wd <= 1'b0;
                m_last_ref <= p_rr;
                m_addr <= p_req[95:64] % 32'd65536;
                m_line <= {1'b1, p_fr, p_req[95:80], 2'b00, p_req[63:0]};
            end
        end
    end

    // Per-cycle comparison on the falling edge, plus a log of granted requesters.
    always @(negedge clk) begin
        chk("fill_ready", fill_ready_o, p_fr);
        chk("refill_ready", refill_ready_o, p_rr);
        chk("awvalid", awvalid_o, p_awv);
        chk("wvalid", wvalid_o, p_wv);
        chk("wlast", wlast_o, p_wv);
        chk("outstanding", outstanding_o, m_cnt);
        chk("err", err_o, m_err);
        chk("bready", bready_o, m_bready);
        chk("awid", awid_o, 4'h0);
        if (p_awv) chk("awaddr", awaddr_o, m_addr);
        if (p_wv) chk("wdata", wdata_o, m_line);
        if (refill_valid && refill_ready_o) grant_log.push_back(1'b1);
        else if (fill_valid && fill_ready_o) grant_log.push_back(1'b0);
    end

    typedef struct {
        bit          is_fill;
        logic [31:0] addr;
        logic [63:0] data;
        logic [31:0] exp_addr;
        logic [83:0] exp_line;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        vecs[0] = '{1'b1, 32'h0001_2340, 64'h0000_0000_0000_00A5, 32'h0000_2340, 84'hC0004_00000000000000A5};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 64'h0123_4567_89AB_CDEF, 32'h0000_FFFF, 84'hBFFFC_0123456789ABCDEF};
        vecs[2] = '{1'b1, 32'hABCD_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 84'hEAF34_FFFFFFFFFFFFFFFF};
        vecs[3] = '{1'b0, 32'h8000_FFC0, 64'h0000_0000_0000_0000, 32'h0000_FFC0, 84'hA0000_0000000000000000};

        bid = 4'h5; bresp = 2'b00; fill_data = 96'h0; refill_data = 96'h0;
        fill_valid = 1'b0; refill_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_awvalid", awvalid_o, 1'b0);
        chk("rst_wvalid", wvalid_o, 1'b0);
        chk("rst_bready", bready_o, 1'b0);
        chk("rst_outstanding", outstanding_o, 4'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_awaddr", awaddr_o, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("bready_after_rst", bready_o, 1'b1);

        // Line build table, zero-wait AXI, B okay after each write.
        awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_valid = vecs[i].is_fill;
            refill_valid = !vecs[i].is_fill;
            fill_data = {vecs[i].addr, vecs[i].data};
            refill_data = {vecs[i].addr, vecs[i].data};
            tick();
            fill_valid = 1'b0; refill_valid = 1'b0;
            chk("tbl_awvalid", awvalid_o, 1'b1);
            chk("tbl_awaddr", awaddr_o, vecs[i].exp_addr);
            chk("tbl_wdata", wdata_o, vecs[i].exp_line);
            tick();
            chk("tbl_done", awvalid_o, 1'b0);
            chk("tbl_out1", outstanding_o, 4'd1);
            bvalid = 1'b1;
            tick();
            bvalid = 1'b0;
            chk("tbl_out0", outstanding_o, 4'd0);
        end

        // Round-robin with both requesters continuously valid.
        do_reset();
        awready = 1'b1; wready = 1'b1;
        fill_data = {32'h0000_0100, 64'h1}; refill_data = {32'h0000_0200, 64'h2};
        fill_valid = 1'b1; refill_valid = 1'b1;
        for (int c = 0; c < 100 && grant_log.size() < 8; c++) begin
            tick();
            bvalid = (outstanding_o != 4'd0);
            nr = 0;
            foreach (grant_log[k]) nr += grant_log[k];
            refill_valid = (nr < 4);
            fill_valid = ((grant_log.size() - nr) < 4);
        end
        fill_valid = 1'b0; refill_valid = 1'b0; bvalid = 1'b0;
        chk("rr_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < grant_log.size()) chk("rr_order", grant_log[k], (k % 2 == 0));

        // AW ready delayed three cycles, W immediate.
        do_reset();
        awready = 1'b0; wready = 1'b1;
        fill_valid = 1'b1; fill_data = {32'h0042_1040, 64'h1111};
        tick();
        fill_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) awready = 1'b1;
            chk("dly_awvalid", awvalid_o, 1'b1);
            chk("dly_awaddr", awaddr_o, 32'h0000_1040);
            chk("dly_wvalid", wvalid_o, (c == 0));
            tick();
        end
        chk("dly_aw_dropped", awvalid_o, 1'b0);
        fill_valid = 1'b1;
        #1;
        chk("dly_back_idle", fill_ready_o, 1'b1);
        fill_valid = 1'b0;

        // Both ready together: exactly one send cycle.
        tick();
        wready = 1'b1;
        fill_valid = 1'b1;
        tick();
        fill_valid = 1'b0;
        chk("one_cyc_aw", awvalid_o, 1'b1);
        chk("one_cyc_w", wvalid_o, 1'b1);
        tick();
        chk("one_cyc_aw_off", awvalid_o, 1'b0);
        chk("one_cyc_w_off", wvalid_o, 1'b0);

        // Outstanding limit with B withheld, then a single B admits one more.
        do_reset();
        awready = 1'b1; wready = 1'b1;
        fill_valid = 1'b1; fill_data = {32'h0000_0300, 64'h3};
        repeat (12) tick();
        chk("lim_out4", outstanding_o, 4'd4);
        chk("lim_no_ready", fill_ready_o, 1'b0);
        chk("lim_grants4", grant_log.size(), 4);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        repeat (6) tick();
        chk("lim_out4_again", outstanding_o, 4'd4);
        chk("lim_no_ready2", fill_ready_o, 1'b0);
        chk("lim_grants5", grant_log.size(), 5);
        fill_valid = 1'b0;

        // B at zero outstanding: error, count stays 0.
        do_reset();
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("b_at_zero_err", err_o, 1'b1);
        chk("b_at_zero_cnt", outstanding_o, 4'd0);

        // SLVERR response sets a sticky error.
        do_reset();
        awready = 1'b1; wready = 1'b1;
        fill_valid = 1'b1;
        tick();
        fill_valid = 1'b0;
        tick();
        chk("slverr_pre", err_o, 1'b0);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk("slverr_err", err_o, 1'b1);
        chk("slverr_cnt", outstanding_o, 4'd0);
        repeat (3) tick();
        chk("slverr_sticky", err_o, 1'b1);

        // Reset pulsed during a send.
        do_reset();
        awready = 1'b0; wready = 1'b0;
        fill_valid = 1'b1;
        tick();
        fill_valid = 1'b0;
        chk("ar_pre_aw", awvalid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_aw_drop", awvalid_o, 1'b0);
        chk("ar_w_drop", wvalid_o, 1'b0);
        chk("ar_bready", bready_o, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("ar_out0", outstanding_o, 4'd0);
        chk("ar_idle_aw", awvalid_o, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            fill_valid = ($urandom_range(0, 3) != 0);
            refill_valid = ($urandom_range(0, 1) != 0);
            fill_data = {$urandom, $urandom, $urandom};
            refill_data = {$urandom, $urandom, $urandom};
            awready = ($urandom_range(0, 3) != 0);
            wready = ($urandom_range(0, 3) != 0);
            bvalid = (outstanding_o != 4'd0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        fill_valid = 1'b0; refill_valid = 1'b0; bvalid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
